usb_cmd_parser: RTL

Downstream consumer of the USB slave-FIFO read path. It takes the 16-bit command words strobed by cmd_flag/cmd_data and hunts for a framed command. It buffers the payload and verifies a 16-bit additive checksum. Only a good frame is committed to the register bus as a burst of single-cycle writes; bad or stalled frames are discarded and flagged.

---
 rtl/usb_cmd_parser.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/usb_cmd_parser.sv
// usb_cmd_parser: hunts for framed commands in the USB slave-FIFO word stream,
// buffers the payload, verifies the additive checksum, and commits good frames
// to the register bus as a burst of single-cycle writes.
//
// Word handshake: cmd_flag is a one-cycle valid for cmd_data. One word is
// accepted on every rising CLCOK edge where cmd_flag=1. There is no ready or
// backpressure, so a word that arrives while a commit is in progress is dropped
// and flagged as an overrun.
module usb_cmd_parser #(
    parameter int          MAX_LEN  = 16,
    parameter int          TIMEOUT  = 1024,
    parameter logic [15:0] HDR_WORD = 16'h55AA
) (
    input  logic        CLCOK,
    input  logic        rst_n,
    input  logic        cmd_flag,
    input  logic [15:0] cmd_data,
    output logic        reg_wr_en,
    output logic [7:0]  reg_addr,
    output logic [15:0] reg_wr_data,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [2:0]  err_code,
    output logic        busy
);

    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_OPC    = 3'd1,
        S_LEN    = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4,
        S_COMMIT = 3'd5
    } state_t;

    // Current FSM state; kept as a plainly named signal so checkers can bind to it.
    state_t      state, state_nxt;
    logic        op_inc, op_inc_nxt;     // 1: incrementing address, 0: fixed address
    logic [7:0]  base_addr, base_nxt;
    logic [7:0]  len, len_nxt;
    logic [7:0]  idx, idx_nxt;           // payload index in DATA, write index in COMMIT
    logic [15:0] sum, sum_nxt;
    logic [TW-1:0] tcnt, tcnt_nxt;

    logic        wr_en_nxt;
    logic [7:0]  addr_nxt;
    logic [15:0] data_nxt;
    logic        ok_nxt;
    logic        err_nxt;
    logic [2:0]  code_nxt;
    logic        buf_we;
    logic [7:0]  idx_p1;

    logic [15:0] buffer [MAX_LEN];

    assign idx_p1 = idx + 8'd1;

    // Next-state, datapath and registered-output values.
    always_comb begin
        state_nxt  = state;
        op_inc_nxt = op_inc;
        base_nxt   = base_addr;
        len_nxt    = len;
        idx_nxt    = idx;
        sum_nxt    = sum;
        tcnt_nxt   = '0;
        wr_en_nxt  = 1'b0;
        addr_nxt   = reg_addr;
        data_nxt   = reg_wr_data;
        ok_nxt     = 1'b0;
        err_nxt    = 1'b0;
        code_nxt   = err_code;
        buf_we     = 1'b0;

        case (state)
            S_IDLE: begin
                if (cmd_flag && (cmd_data == HDR_WORD)) begin
                    state_nxt = S_OPC;
                end
            end

            S_OPC, S_LEN, S_DATA, S_CSUM: begin
                if (!cmd_flag) begin
                    // A word arriving on the deadline cycle wins over the timeout.
                    if (tcnt == TW'(TIMEOUT - 1)) begin
                        err_nxt   = 1'b1;
                        code_nxt  = 3'd4;
                        state_nxt = S_IDLE;
                    end else begin
                        tcnt_nxt = tcnt + TW'(1);
                    end
                end else begin
                    case (state)
                        S_OPC: begin
                            if ((cmd_data[15:8] == 8'h01) || (cmd_data[15:8] == 8'h02)) begin
                                op_inc_nxt = (cmd_data[15:8] == 8'h01);
                                base_nxt   = cmd_data[7:0];
                                sum_nxt    = cmd_data;
                                state_nxt  = S_LEN;
                            end else begin
                                err_nxt   = 1'b1;
                                code_nxt  = 3'd1;
                                state_nxt = S_IDLE;
                            end
                        end
                        S_LEN: begin
                            if ((cmd_data[15:8] != 8'h00) || (cmd_data[7:0] == 8'h00) ||
                                (cmd_data[7:0] > 8'(MAX_LEN))) begin
                                err_nxt   = 1'b1;
                                code_nxt  = 3'd2;
                                state_nxt = S_IDLE;
                            end else begin
                                len_nxt   = cmd_data[7:0];
                                sum_nxt   = sum + cmd_data;
                                idx_nxt   = 8'd0;
                                state_nxt = S_DATA;
                            end
                        end
                        S_DATA: begin
                            buf_we  = 1'b1;
                            sum_nxt = sum + cmd_data;
                            if (idx == (len - 8'd1)) begin
                                state_nxt = S_CSUM;
                            end else begin
                                idx_nxt = idx_p1;
                            end
                        end
                        default: begin
                            // S_CSUM: first write is presented in the cycle after the match.
                            if (cmd_data == sum) begin
                                state_nxt = S_COMMIT;
                                idx_nxt   = 8'd0;
                                wr_en_nxt = 1'b1;
                                addr_nxt  = base_addr;
                                data_nxt  = buffer[0];
                                ok_nxt    = (len == 8'd1);
                            end else begin
                                err_nxt   = 1'b1;
                                code_nxt  = 3'd3;
                                state_nxt = S_IDLE;
                            end
                        end
                    endcase
                end
            end

            S_COMMIT: begin
                // Overrun: the word is dropped but the burst keeps going.
                if (cmd_flag) begin
                    err_nxt  = 1'b1;
                    code_nxt = 3'd5;
                end
                if (idx == (len - 8'd1)) begin
                    state_nxt = S_IDLE;
                end else begin
                    idx_nxt   = idx_p1;
                    wr_en_nxt = 1'b1;
                    addr_nxt  = op_inc ? (base_addr + idx_p1) : base_addr;
                    data_nxt  = buffer[idx_p1[IW-1:0]];
                    ok_nxt    = (idx_p1 == (len - 8'd1));
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, context and output registers with synchronous active-low reset.
    always_ff @(posedge CLCOK) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            op_inc      <= 1'b0;
            base_addr   <= 8'd0;
            len         <= 8'd0;
            idx         <= 8'd0;
            sum         <= 16'd0;
            tcnt        <= '0;
            reg_wr_en   <= 1'b0;
            reg_addr    <= 8'd0;
            reg_wr_data <= 16'd0;
            frame_ok    <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= 3'd0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            op_inc      <= op_inc_nxt;
            base_addr   <= base_nxt;
            len         <= len_nxt;
            idx         <= idx_nxt;
            sum         <= sum_nxt;
            tcnt        <= tcnt_nxt;
            reg_wr_en   <= wr_en_nxt;
            reg_addr    <= addr_nxt;
            reg_wr_data <= data_nxt;
            frame_ok    <= ok_nxt;
            frame_err   <= err_nxt;
            err_code    <= code_nxt;
            busy        <= (state_nxt != S_IDLE);
        end
    end

    // Payload buffer; contents are don't-care after reset.
    always_ff @(posedge CLCOK) begin
        if (buf_we) begin
            buffer[idx[IW-1:0]] <= cmd_data;
        end
    end

endmodule
